// File: rtl/negate_rr_scheduler.sv
// negate_rr_scheduler: round-robin shared two's-complement negation with registered result
module negate_rr_scheduler #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   localparam int IDW  = $clog2(NREQ)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [IDW-1:0]          out_id,
   output logic                    out_ovf,
   output logic [7:0]              busy_cnt
);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;
   logic [0:0]       state;
   logic [IDW-1:0]   rr_ptr, g, idx;
   logic             found, accept;
   logic [WIDTH-1:0] op;
   always_comb begin
      found = 1'b0;
      g = '0;
      idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(rr_ptr) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            g = idx;
         end
      end
   end
   // reset gates the grant so req_ready is quiet while rst_n is low
   assign accept    = rst_n && found && (state == EMPTY || out_ready);
   assign req_ready = accept ? NREQ'(1) << g : '0;
   assign op        = req_data[g*WIDTH +: WIDTH];
   assign out_valid = (state == FULL);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         out_data <= '0;
         out_id   <= '0;
         out_ovf  <= 1'b0;
         busy_cnt <= '0;
         rr_ptr   <= '0;
      end else begin
         if (accept) begin
            state    <= FULL;
            out_data <= ~op + WIDTH'(1);
            out_id   <= g;
            out_ovf  <= (op == {1'b1, {(WIDTH-1){1'b0}}});
            rr_ptr   <= (g == IDW'(NREQ-1)) ? '0 : g + IDW'(1);
         end else if (out_ready) begin
            state <= EMPTY;
         end
         if (state == FULL && !out_ready && busy_cnt != 8'hFF)
            busy_cnt <= busy_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_negate_rr_scheduler.sv
// tb_negate_rr_scheduler: directed and random checks against a behavioural model
module tb_negate_rr_scheduler;
   localparam int W = 4;
   localparam int N = 4;
   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   req_ready;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [W-1:0]   out_data;
   logic [1:0]     out_id;
   logic           out_ovf;
   logic [7:0]     busy_cnt;
   int pass_cnt = 0, tot_cnt = 0;
   int m_valid = 0, m_data = 0, m_id = 0, m_ovf = 0, m_busy = 0, m_ptr = 0;
   int t3_ids[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int t5_rdy[4] = '{8, 2, 8, 2};

   always #5 clk = ~clk;

   negate_rr_scheduler #(.WIDTH(W), .NREQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_id(out_id), .out_ovf(out_ovf), .busy_cnt(busy_cnt)
   );

   task automatic chk(input string nm, input int got, input int exp);
      tot_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
      @(posedge clk);
      #1;
      req_valid = v;
      req_data  = d;
      out_ready = r;
      #2;
   endtask

   // Model: inputs are stable between posedge+1 and the next posedge, so the
   // state computed here at negedge is what the DUT registers at the next edge.
   always @(negedge clk) begin
      int g, x, er;
      if (!rst_n) begin
         m_valid = 0; m_data = 0; m_id = 0; m_ovf = 0; m_busy = 0; m_ptr = 0;
      end
      g = -1;
      if (rst_n && (!m_valid || out_ready))
         for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      er = (g < 0) ? 0 : (1 << g);
      chk("m_req_ready", int'(req_ready), er);
      chk("m_out_valid", int'(out_valid), m_valid);
      chk("m_out_data", int'(out_data), m_data);
      chk("m_out_id", int'(out_id), m_id);
      chk("m_out_ovf", int'(out_ovf), m_ovf);
      chk("m_busy_cnt", int'(busy_cnt), m_busy);
      if (rst_n) begin
         if (m_valid && !out_ready && m_busy < 255) m_busy++;
         if (g >= 0) begin
            x = int'(req_data[g*W +: W]);
            m_data  = ((1 << W) - x) % (1 << W);
            m_id    = g;
            m_ovf   = (x == (1 << (W-1)));
            m_valid = 1;
            m_ptr   = (g + 1) % N;
         end else if (out_ready) m_valid = 0;
      end
   end

   initial begin
      drive(4'hF, 16'h0000, 1'b1);
      drive(4'hF, 16'h0000, 1'b1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_busy", int'(busy_cnt), 0);
      chk("rst_out_data", int'(out_data), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_valid = '0;
      // single request
      drive(4'b0001, 16'h0003, 1'b1);
      chk("t1_ready", int'(req_ready), 1);
      drive(4'b0000, 16'h0000, 1'b1);
      chk("t1_valid", int'(out_valid), 1);
      chk("t1_data", int'(out_data), 13);
      chk("t1_id", int'(out_id), 0);
      chk("t1_ovf", int'(out_ovf), 0);
      // sweep on requester 2
      for (int x = 0; x <= 16; x++) begin
         drive(x < 16 ? 4'b0100 : 4'b0000, 16'(x % 16) << 8, 1'b1);
         if (x > 0) begin
            chk("t2_data", int'(out_data), (16 - (x - 1)) % 16);
            chk("t2_ovf", int'(out_ovf), int'(x - 1 == 8));
            chk("t2_id", int'(out_id), 2);
         end
         if (x == 1) chk("t2_zero", int'(out_data), 0);
         if (x == 9) chk("t2_most_neg", int'(out_data), 8);
      end
      // fairness: park pointer at 0 via requester 3, then all valid
      drive(4'b1000, 16'h0000, 1'b1);
      for (int i = 0; i <= 8; i++) begin
         drive(i < 8 ? 4'hF : 4'h0, 16'h1234, 1'b1);
         if (i > 0) chk("t3_id", int'(out_id), t3_ids[i-1]);
      end
      // backpressure
      drive(4'b0010, 16'h0050, 1'b1);
      for (int s = 0; s < 5; s++) begin
         drive(4'b0010, 16'h0060, 1'b0);
         chk("t4_ready", int'(req_ready), 0);
         chk("t4_data", int'(out_data), 11);
         chk("t4_id", int'(out_id), 1);
      end
      drive(4'b0010, 16'h0070, 1'b1);
      chk("t4_busy", int'(busy_cnt), 5);
      chk("t4_drain_ready", int'(req_ready), 2);
      drive(4'b0000, 16'h0000, 1'b1);
      chk("t4_next_data", int'(out_data), 9);
      chk("t4_next_id", int'(out_id), 1);
      // wrap/skip from pointer 3
      drive(4'b0100, 16'h0000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(4'b1010, 16'h0000, 1'b1);
         chk("t5_ready", int'(req_ready), t5_rdy[i]);
      end
      // long stall saturates busy_cnt
      repeat (300) drive(4'b0000, 16'h0000, 1'b0);
      chk("sat_busy", int'(busy_cnt), 255);
      chk("sat_valid", int'(out_valid), 1);
      // reset while full with requests pending
      drive(4'hF, 16'h1111, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", int'(out_valid), 0);
      chk("t6_async_ready", int'(req_ready), 0);
      chk("t6_async_busy", int'(busy_cnt), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_valid = 4'b0101;
      req_data = 16'h0304;
      out_ready = 1'b1;
      #2;
      chk("t6_ready", int'(req_ready), 1);
      drive(4'b0000, 16'h0000, 1'b1);
      chk("t6_id", int'(out_id), 0);
      chk("t6_data", int'(out_data), 12);
      // random traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         rst_n = ($urandom_range(199) != 0);
         req_valid = N'($urandom);
         req_data = (N*W)'($urandom);
         out_ready = ($urandom_range(3) != 0);
      end
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
